instruction_decode_queue: RTL
=============================

Name: instruction_decode_queue

Overview:
- Downstream consumer of the 32-bit instruction assembler.
- Captures each assembled word on a one-cycle valid pulse and buffers it in a small FIFO.
- Splits each word into decoded fields and presents it through a registered valid/ready handshake to the execute stage.
- Decouples byte-serial instruction assembly from execute-stage stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle pulse: in_word holds a complete instruction.
- in_word  in  32  assembled instruction.
- in_ready  out  1  FIFO not full.
- dec_valid  out  1  decoded instruction present on dec_* outputs.
- dec_ready  in  1  execute stage accepts the current instruction this cycle.
- dec_opcode  out  4  in_word[31:28].
- dec_rd  out  4  in_word[27:24].
- dec_rs1  out  4  in_word[23:20].
- dec_rs2  out  4  in_word[19:16].
- dec_imm  out  32  in_word[15:0], sign-extended.
- dec_illegal  out  1  opcode is reserved (4'hE or 4'hF).
- overflow  out  1  sticky: a push was attempted while full.
- occupancy  out  CNT_W  FIFO entry count, excluding the output register.

Behaviour:
- Reset (synchronous, active-high): sets dec_valid=0, all dec_* fields=0, overflow=0, occupancy=0, and clears read/write pointers. in_ready=1 from the first cycle after reset.
- rst asserted mid-operation discards all queued and presented instructions. No partial state survives.
- Push: when in_valid=1 and occupancy<DEPTH at a posedge, in_word is written at wptr, wptr increments (wrapping mod DEPTH), and occupancy increments.
- in_ready = (occupancy<DEPTH). It is combinational from the counter only; a same-cycle pop does not free a slot.
- Push while full: the word is dropped, overflow is set and held until reset, and pointers are unchanged.
- Output register load condition: occupancy>0 AND (dec_valid=0 OR dec_ready=1).
  - On load, the entry at rptr is decoded into the dec_* registers, dec_valid=1, rptr increments (wrapping), and occupancy decrements.
- When dec_valid=1 and dec_ready=1 with occupancy=0: dec_valid goes to 0 next cycle. Field values hold their last value (don't care).
- When dec_valid=1 and dec_ready=0: all dec_* outputs are held stable. No FIFO read occurs.
- Simultaneous push and load in the same cycle: occupancy is unchanged, and both pointers advance.
- Latency: word pushed at edge N (queue empty, dec_valid=0) → dec_valid=1 with its fields after edge N+1.
- Throughput: one instruction per cycle when dec_ready is held high.
- Decode rules:
  - dec_imm = {{16{w[15]}}, w[15:0]}.
  - dec_illegal = (w[31:28] >= 4'hE).
  - Illegal instructions are still delivered, flagged; they are never dropped.
- Ordering: strict FIFO. No reordering or bypass path; data always passes through the FIFO.

Decomposition:
- Package decode_pkg:
  - opcode_t enum, 4-bit, values 0x0–0xD, with OP_RSV_E and OP_RSV_F.
  - Field bit-position localparams: OPC_HI/LO, RD_HI/LO, RS1_HI/LO, RS2_HI/LO, IMM_HI/LO.
  - decoded_t packed struct {opcode, rd, rs1, rs2, imm32, illegal}.
  - decode function mapping a 32-bit word to decoded_t.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds the storage, pointers and occupancy. The top level contains the decode function call and the output register.

Test Plan:
- Reset then single push of 32'h1234_8001 at edge 5 → dec_valid=1 after edge 6; opcode=1, rd=2, rs1=3, rs2=4, imm=32'hFFFF_8001, illegal=0.
- dec_ready=0; push 5 words → occupancy=4 after the 5th accepted push (1 in the output register, 4 in the FIFO). in_ready=0. A 6th push sets overflow=1 and that word never appears.
- dec_ready held 1 with a push every cycle of words 0..7 → dec_valid stays 1 from cycle 2, each word is delivered once in order, occupancy≤1.
- Push 32'hE000_0000 and 32'hF0FF_7FFF → dec_illegal=1 on both; imm of the second is 32'h0000_7FFF.
- dec_ready toggled in a 1,0 pattern over 2×DEPTH words → no loss, no duplication, and dec_* held stable whenever dec_ready=0. Pointer wrap exercised.
- With the queue full and dec_valid=1, assert rst for one cycle → next cycle dec_valid=0, occupancy=0, overflow=0, in_ready=1. A subsequent push is delivered normally.

Source files
------------

// File: rtl/decode_pkg.sv
// Instruction field layout, opcode encoding and the word-to-fields decode
// shared by the decode queue.
package decode_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 24;
    localparam int RS1_HI = 23;
    localparam int RS1_LO = 20;
    localparam int RS2_HI = 19;
    localparam int RS2_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_0     = 4'h0,
        OP_1     = 4'h1,
        OP_2     = 4'h2,
        OP_3     = 4'h3,
        OP_4     = 4'h4,
        OP_5     = 4'h5,
        OP_6     = 4'h6,
        OP_7     = 4'h7,
        OP_8     = 4'h8,
        OP_9     = 4'h9,
        OP_A     = 4'hA,
        OP_B     = 4'hB,
        OP_C     = 4'hC,
        OP_D     = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm32;
        logic        illegal;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] w);
        decoded_t d;
        d.opcode  = opcode_t'(w[OPC_HI:OPC_LO]);
        d.rd      = w[RD_HI:RD_LO];
        d.rs1     = w[RS1_HI:RS1_LO];
        d.rs2     = w[RS2_HI:RS2_LO];
        d.imm32   = {{16{w[IMM_HI]}}, w[IMM_HI:IMM_LO]};
        d.illegal = (w[OPC_HI:OPC_LO] >= 4'hE);
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter and sticky overflow flag.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rdata    = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/instruction_decode_queue.sv
// Buffers assembled instruction words and presents them decoded through a
// registered valid/ready output stage.
module instruction_decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    output logic             in_ready,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [3:0]       dec_opcode,
    output logic [3:0]       dec_rd,
    output logic [3:0]       dec_rs1,
    output logic [3:0]       dec_rs2,
    output logic [31:0]      dec_imm,
    output logic             dec_illegal,
    output logic             overflow,
    output logic [CNT_W-1:0] occupancy
);
    logic [31:0]      w_fifo_rdata;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_load;
    logic             r_dec_valid;
    decoded_t         r_dec;

    assign w_load = (w_count != '0) && (!r_dec_valid || dec_ready);

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (in_valid),
        .i_wdata   (in_word),
        .i_pop     (w_load),
        .o_rdata   (w_fifo_rdata),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_overflow(overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec       <= '0;
        end else if (w_load) begin
            r_dec_valid <= 1'b1;
            r_dec       <= decode(w_fifo_rdata);
        end else if (dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign in_ready    = !w_full;
    assign occupancy   = w_count;
    assign dec_valid   = r_dec_valid;
    assign dec_opcode  = r_dec.opcode;
    assign dec_rd      = r_dec.rd;
    assign dec_rs1     = r_dec.rs1;
    assign dec_rs2     = r_dec.rs2;
    assign dec_imm     = r_dec.imm32;
    assign dec_illegal = r_dec.illegal;

endmodule
